// File: rtl/selection_pkg.sv
// Shared types, widths, note constants and melody tables for the selection judge.
package selection_pkg;

  localparam int unsigned NUM_DIGITS = 7;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned CODE_W     = NUM_DIGITS * DIGIT_W;
  localparam int unsigned NOTE_W     = 3;
  localparam int unsigned MAX_NOTES  = 7;
  localparam int unsigned MELODY_W   = NOTE_W * MAX_NOTES;
  localparam int unsigned LEN_W      = 3;
  localparam int unsigned TICK_W     = 28;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    COMPARE,
    GRADE,
    ANNOUNCE,
    DONE
  } state_e;

  typedef logic [NOTE_W-1:0] note_t;

  localparam note_t NOTE_OFF = 3'd0;
  localparam note_t NOTE_DO  = 3'd1;
  localparam note_t NOTE_RE  = 3'd2;
  localparam note_t NOTE_MI  = 3'd3;
  localparam note_t NOTE_FA  = 3'd4;
  localparam note_t NOTE_SO  = 3'd5;
  localparam note_t NOTE_LA  = 3'd6;
  localparam note_t NOTE_TI  = 3'd7;

  localparam logic [CNT_W-1:0] WIN_MIN = 3'd4;

  // First note sits in notes[2:0]; len counts how many notes are played.
  typedef struct packed {
    logic [LEN_W-1:0]    len;
    logic [MELODY_W-1:0] notes;
  } melody_t;

  localparam melody_t MEL_JACKPOT = {3'd7, NOTE_TI, NOTE_LA, NOTE_SO, NOTE_FA,
                                     NOTE_MI, NOTE_RE, NOTE_DO};
  localparam melody_t MEL_BIG     = {3'd3, NOTE_OFF, NOTE_OFF, NOTE_OFF, NOTE_OFF,
                                     NOTE_SO, NOTE_MI, NOTE_DO};
  localparam melody_t MEL_SMALL   = {3'd1, NOTE_OFF, NOTE_OFF, NOTE_OFF, NOTE_OFF,
                                     NOTE_OFF, NOTE_OFF, NOTE_DO};
  localparam melody_t MEL_NONE    = '0;

  function automatic note_t note_at(input logic [MELODY_W-1:0] notes,
                                    input logic [LEN_W-1:0] idx);
    return notes[int'(idx)*NOTE_W +: NOTE_W];
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_at(input logic [CODE_W-1:0] c,
                                                  input logic [IDX_W-1:0] idx);
    return c[int'(idx)*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/selection_judge_note_sequencer.sv
// Plays a packed note list on bell_code: each note for NOTE_TICKS cycles, then GAP_TICKS of silence.
module note_sequencer
  import selection_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 12500000,
  parameter int unsigned GAP_TICKS  = 2500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [MELODY_W-1:0] melody,
  input  logic [LEN_W-1:0]    length,
  output logic [NOTE_W-1:0]   bell_code,
  output logic                note_start_c,
  output logic                finished_c
);

  localparam bit                HAS_GAP   = (GAP_TICKS != 0);
  localparam logic [TICK_W-1:0] NOTE_LAST = TICK_W'(NOTE_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = HAS_GAP ? TICK_W'(GAP_TICKS - 1) : '0;

  logic                active_q, active_d;
  logic                in_gap_q, in_gap_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [MELODY_W-1:0] mel_q, mel_d;
  logic [LEN_W-1:0]    len_q, len_d;
  note_t               bell_q, bell_d;

  logic note_end, gap_end, seg_end, last_note;

  // Segment boundary decode; a note without a gap ends its segment directly.
  always_comb begin
    note_end  = active_q && !in_gap_q && (tick_q == NOTE_LAST);
    gap_end   = active_q && in_gap_q && (tick_q == GAP_LAST);
    seg_end   = HAS_GAP ? gap_end : note_end;
    last_note = (idx_q == len_q - LEN_W'(1));
  end

  assign note_start_c = start || (seg_end && !last_note);
  assign finished_c   = seg_end && last_note;
  assign bell_code    = bell_q;

  always_comb begin
    active_d = active_q;
    in_gap_d = in_gap_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    mel_d    = mel_q;
    len_d    = len_q;
    bell_d   = bell_q;
    if (stop) begin
      active_d = 1'b0;
      in_gap_d = 1'b0;
      tick_d   = '0;
      idx_d    = '0;
      bell_d   = NOTE_OFF;
    end else if (start) begin
      active_d = 1'b1;
      in_gap_d = 1'b0;
      tick_d   = '0;
      idx_d    = '0;
      mel_d    = melody;
      len_d    = length;
      bell_d   = note_at(melody, LEN_W'(0));
    end else if (active_q) begin
      if (HAS_GAP && note_end) begin
        in_gap_d = 1'b1;
        tick_d   = '0;
        bell_d   = NOTE_OFF;
      end else if (seg_end) begin
        tick_d   = '0;
        in_gap_d = 1'b0;
        if (last_note) begin
          active_d = 1'b0;
          idx_d    = '0;
          bell_d   = NOTE_OFF;
        end else begin
          idx_d  = idx_q + LEN_W'(1);
          bell_d = note_at(mel_q, idx_q + LEN_W'(1));
        end
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      in_gap_q <= 1'b0;
      tick_q   <= '0;
      idx_q    <= '0;
      mel_q    <= '0;
      len_q    <= '0;
      bell_q   <= NOTE_OFF;
    end else begin
      active_q <= active_d;
      in_gap_q <= in_gap_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      mel_q    <= mel_d;
      len_q    <= len_d;
      bell_q   <= bell_d;
    end
  end

endmodule

// File: rtl/selection_judge.sv
// Snapshots the stopped digit code, grades it against target and plays a grade jingle.
// JUDGE_PARTIAL_MELODY_EN enables the 4..6 and 1..3 match jingles; otherwise only a jackpot plays.
module selection_judge
  import selection_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 12500000,
  parameter int unsigned GAP_TICKS  = 2500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] flag,
  input  logic [CODE_W-1:0]     code,
  input  logic [CODE_W-1:0]     target,
  output logic [NOTE_W-1:0]     bell_code,
  output logic [CNT_W-1:0]      match_cnt,
  output logic                  win,
  output logic                  blink_en,
  output logic                  busy,
  output logic                  done
);

  state_e                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   prev_flag_q, prev_flag_d;
  logic [CODE_W-1:0]       snap_q, snap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        match_cnt_q, match_cnt_d;
  logic                    win_q, win_d;
  logic                    blink_q, blink_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic    start_c, stop_c, note_start_c, finished_c, flag_run;
  melody_t mel_sel;

  always_comb begin
    mel_sel = MEL_NONE;
    if (cnt_q == CNT_W'(NUM_DIGITS)) begin
      mel_sel = MEL_JACKPOT;
    end
`ifdef JUDGE_PARTIAL_MELODY_EN
    else if (cnt_q >= WIN_MIN) begin
      mel_sel = MEL_BIG;
    end else if (cnt_q != '0) begin
      mel_sel = MEL_SMALL;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    prev_flag_d = flag;
    snap_d      = snap_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    match_cnt_d = match_cnt_q;
    win_d       = win_q;
    start_c     = 1'b0;
    stop_c      = 1'b0;
    flag_run    = (flag != '0);
    case (state_q)
      IDLE: begin
        if ((prev_flag_q != '0) && !flag_run) begin
          state_d = CAPTURE;
          snap_d  = code;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      CAPTURE: state_d = COMPARE;
      COMPARE: begin
        if (digit_at(snap_q, idx_q) == digit_at(target, idx_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
          state_d = GRADE;
          idx_d   = '0;
        end
      end
      GRADE: begin
        match_cnt_d = cnt_q;
        win_d       = (cnt_q >= WIN_MIN);
        if (mel_sel.len != '0) begin
          state_d = ANNOUNCE;
          start_c = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      ANNOUNCE: begin
        if (finished_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (flag_run) begin
          state_d     = IDLE;
          match_cnt_d = '0;
          win_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A sequencer restarting mid-run abandons the judgement.
    if (flag_run && (state_q inside {CAPTURE, COMPARE, GRADE, ANNOUNCE})) begin
      state_d     = IDLE;
      stop_c      = 1'b1;
      start_c     = 1'b0;
      idx_d       = '0;
      match_cnt_d = '0;
      win_d       = 1'b0;
    end
    busy_d = (state_d inside {CAPTURE, COMPARE, GRADE, ANNOUNCE});
    done_d = (state_d == DONE);
  end

  // Blink flips on every note start of a winning jingle and drops once it ends.
  always_comb begin
    blink_d = blink_q;
    if (stop_c || finished_c) begin
      blink_d = 1'b0;
    end else if (note_start_c && win_d) begin
      blink_d = ~blink_q;
    end
  end

  note_sequencer #(
    .NOTE_TICKS (NOTE_TICKS),
    .GAP_TICKS  (GAP_TICKS)
  ) u_note_sequencer (
    .clk          (clk),
    .rst          (rst),
    .start        (start_c),
    .stop         (stop_c),
    .melody       (mel_sel.notes),
    .length       (mel_sel.len),
    .bell_code    (bell_code),
    .note_start_c (note_start_c),
    .finished_c   (finished_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_flag_q <= '0;
      snap_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      win_q       <= 1'b0;
      blink_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_flag_q <= prev_flag_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      match_cnt_q <= match_cnt_d;
      win_q       <= win_d;
      blink_q     <= blink_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign match_cnt = match_cnt_q;
  assign win       = win_q;
  assign blink_en  = blink_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_selection_judge.sv
// Randomized self-checking bench for selection_judge against a note-list reference model.
module tb_selection_judge;

  localparam int unsigned NT = 4;
  localparam int unsigned GT = 2;
  localparam logic [27:0] T_JACK = 28'h2F54321;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  flag = 7'h7F;
  logic [27:0] code = '0;
  logic [27:0] target = '0;
  logic [2:0]  bell_code;
  logic [2:0]  match_cnt;
  logic        win, blink_en, busy, done;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_bell[$];
  int exp_blink[$];

  always #5 clk = ~clk;

  selection_judge #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst(rst), .flag(flag), .code(code), .target(target),
    .bell_code(bell_code), .match_cnt(match_cnt), .win(win),
    .blink_en(blink_en), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_matches(input logic [27:0] c, input logic [27:0] t);
    int m = 0;
    for (int i = 0; i < 7; i++) if (c[4*i +: 4] == t[4*i +: 4]) m++;
    return m;
  endfunction

  // Expected per-cycle bell/blink from the first ANNOUNCE cycle until DONE.
  task automatic build_expect(input int m);
    int notes[$];
    exp_bell.delete();
    exp_blink.delete();
    if (m == 7) notes = '{1, 2, 3, 4, 5, 6, 7};
`ifdef JUDGE_PARTIAL_MELODY_EN
    else if (m >= 4) notes = '{1, 3, 5};
    else if (m >= 1) notes = '{1};
`endif
    foreach (notes[n]) begin
      for (int k = 0; k < int'(NT); k++) begin
        exp_bell.push_back(notes[n]);
        exp_blink.push_back((m >= 4 && (n % 2) == 0) ? 1 : 0);
      end
      for (int k = 0; k < int'(GT); k++) begin
        exp_bell.push_back(0);
        exp_blink.push_back((m >= 4 && (n % 2) == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic run_case(input logic [27:0] c, input logic [27:0] t, input bit scramble,
                          input string name);
    int m;
    m = model_matches(c, t);
    build_expect(m);
    target = t;
    flag = 7'h7F;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b done=%b, want 0 0", name, busy, done);
    end
    flag = 7'h00;
    code = c;
    tick();
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (busy !== 1'b1 || bell_code !== 3'd0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_pre_grade[%0d]: busy=%b bell=%0d done=%b, want 1 0 0",
                 name, k, busy, bell_code, done);
      end
      if (scramble) code = 28'($urandom);
      tick();
    end
    n_cmp++;
    if (match_cnt !== 3'(m) || win !== (m >= 4)) begin
      n_fail++;
      $display("FAIL %s_grade: match_cnt=%0d win=%b, want %0d %b", name, match_cnt, win, m, m >= 4);
    end
    foreach (exp_bell[i]) begin
      n_cmp++;
      if (bell_code !== 3'(exp_bell[i]) || blink_en !== 1'(exp_blink[i]) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_announce[%0d]: bell=%0d blink=%b busy=%b, want %0d %0d 1",
                 name, i, bell_code, blink_en, busy, exp_bell[i], exp_blink[i]);
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || bell_code !== 3'd0 || blink_en !== 1'b0 ||
        match_cnt !== 3'(m)) begin
      n_fail++;
      $display("FAIL %s_done: done=%b busy=%b bell=%0d blink=%b cnt=%0d, want 1 0 0 0 %0d",
               name, done, busy, bell_code, blink_en, match_cnt, m);
    end
    repeat (3) tick();
    n_cmp++;
    if (done !== 1'b1 || match_cnt !== 3'(m) || win !== (m >= 4)) begin
      n_fail++;
      $display("FAIL %s_hold: done=%b cnt=%0d win=%b, want 1 %0d %b", name, done, match_cnt, win, m, m >= 4);
    end
    flag = 7'h7F;
    tick();
    n_cmp++;
    if (done !== 1'b0 || match_cnt !== 3'd0 || win !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_restart: done=%b cnt=%0d win=%b busy=%b, want 0 0 0 0",
               name, done, match_cnt, win, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flag = 7'h7F;
    #12;
    n_cmp++;
    if ({bell_code, match_cnt, win, blink_en, busy, done} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want 0", {bell_code, match_cnt, win, blink_en, busy, done});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_jackpot();
    run_case(T_JACK, T_JACK, 1'b0, "jackpot");
  endtask

  task automatic test_partial();
    run_case(28'h2F54399, T_JACK, 1'b0, "five");
  endtask

  task automatic test_zero();
    run_case(28'h0A00000, 28'h1B11111, 1'b0, "zero");
  endtask

  task automatic test_abort();
    target = T_JACK;
    flag = 7'h7F;
    tick();
    tick();
    flag = 7'h00;
    code = T_JACK;
    tick();
    repeat (9 + 13) tick();
    n_cmp++;
    if (bell_code !== 3'd3 || blink_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_third_note: bell=%0d blink=%b, want 3 1", bell_code, blink_en);
    end
    flag = 7'h7F;
    tick();
    n_cmp++;
    if (bell_code !== 3'd0 || blink_en !== 1'b0 || match_cnt !== 3'd0 || win !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_edge: bell=%0d blink=%b cnt=%0d win=%b busy=%b done=%b, want all 0",
               bell_code, blink_en, match_cnt, win, busy, done);
    end
    repeat (4) tick();
    n_cmp++;
    if (bell_code !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stays_idle: bell=%0d busy=%b, want 0 0", bell_code, busy);
    end
    run_case(T_JACK, T_JACK, 1'b0, "after_abort");
  endtask

  task automatic test_no_spurious_and_snapshot();
    logic [27:0] t;
    logic [27:0] c;
    flag = 7'h00;
    rst = 1'b1;
    #7;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL no_spurious[%0d]: busy=%b done=%b, want 0 0", k, busy, done);
      end
    end
    for (int r = 0; r < 3; r++) begin
      t = 28'($urandom);
      c = t;
      for (int i = 0; i < 7; i++)
        if ($urandom_range(0, 1) == 1) c[4*i +: 4] = c[4*i +: 4] ^ 4'($urandom_range(1, 15));
      run_case(c, t, 1'b1, "snapshot");
    end
  endtask

  task automatic test_async_reset();
    target = T_JACK;
    flag = 7'h7F;
    tick();
    tick();
    flag = 7'h00;
    code = T_JACK;
    tick();
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bell_code, match_cnt, win, blink_en, busy, done} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_rst_compare: got %b, want 0", {bell_code, match_cnt, win, blink_en, busy, done});
    end
    #3 rst = 1'b0;
    flag = 7'h7F;
    tick();
    tick();
    flag = 7'h00;
    tick();
    repeat (9 + 1) tick();
    n_cmp++;
    if (bell_code !== 3'd1) begin
      n_fail++;
      $display("FAIL async_rst_pre_announce: bell=%0d, want 1", bell_code);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bell_code, match_cnt, win, blink_en, busy, done} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_rst_announce: got %b, want 0", {bell_code, match_cnt, win, blink_en, busy, done});
    end
    #3 rst = 1'b0;
    run_case(28'h2F04321, T_JACK, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [27:0] t;
    logic [27:0] c;
    for (int r = 0; r < 8; r++) begin
      t = 28'($urandom);
      c = t;
      for (int i = 0; i < 7; i++)
        if ($urandom_range(0, 1) == 1) c[4*i +: 4] = c[4*i +: 4] ^ 4'($urandom_range(1, 15));
      run_case(c, t, 1'b0, "random");
    end
    t = 28'($urandom);
    c = t;
    c[11:8] = c[11:8] ^ 4'h5;
    c[23:20] = c[23:20] ^ 4'h1;
    c[27:24] = c[27:24] ^ 4'h8;
    run_case(c, t, 1'b0, "four");
    c[3:0] = c[3:0] ^ 4'hF;
    run_case(c, t, 1'b0, "three");
  endtask

  initial begin
    test_reset();
    test_jackpot();
    test_partial();
    test_zero();
    test_abort();
    test_no_spurious_and_snapshot();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/selection_judge.md
Name: selection_judge

Overview:
- Sits directly downstream of the seven stop-able digit sequencers in the selecting machine. Consumes their run flags and 28-bit code bus.
- Once all seven sequencers have stopped, it snapshots the result and compares it digit by digit against a target pattern.
- Grades the match count and plays a grade-dependent jingle on the 3-bit bell_code bus that feeds the bell tone generator.
- Drives a blink enable for the display masking logic.

Parameters:
- NOTE_TICKS, 12500000, clk cycles each jingle note is held (0.25 s at 50 MHz); legal range 1..2^28-1.
- GAP_TICKS, 2500000, clk cycles of silence (bell_code=0) after each note; 0 means no gap.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- flag  in  7  per-sequencer run flag; 1=running, 0=stopped; bit6=Chinese-glyph digit, bit5=letter digit, bits4..0=numeric digits
- code  in  28  digit codes; digit i at code[4i+3:4i], i=0..6
- target  in  28  winning pattern, same packing as code
- bell_code  out  3  note select to bell: 0=silent, 1..7=high do..ti
- match_cnt  out  3  number of matching digits, 0..7
- win  out  1  match_cnt>=4
- blink_en  out  1  toggles per note while a winning jingle plays
- busy  out  1  high in CAPTURE/COMPARE/GRADE/ANNOUNCE
- done  out  1  high in DONE

Behaviour:
- Reset values:
  - all outputs 0
  - state=IDLE
  - prev_flag=7'h00, so no spurious trigger if flag is already 0 out of reset
  - snapshot=0, digit index=0
- Trigger: registered prev_flag!=0 and flag==0 in IDLE.
  - On that edge: snapshot<=code, state<=CAPTURE, match counter<=0.
- CAPTURE: 1 cycle, no action (snapshot settles). Then COMPARE.
- COMPARE: 7 cycles, idx 0..6.
  - Each cycle: if snapshot nibble idx == target nibble idx, counter+1. Compare all 4 bits.
  - target is sampled live during COMPARE; it must be held stable by its driver.
  - After idx=6: GRADE.
- GRADE: 1 cycle.
  - Registers match_cnt and win, so both are valid from the cycle after GRADE.
  - Selects melody:
    - 7 matches: jackpot, notes 1,2,3,4,5,6,7
    - 4..6 matches: 1,3,5
    - 1..3 matches: 1
    - 0 matches: no melody, go straight to DONE
- ANNOUNCE: each note drives bell_code=note for NOTE_TICKS cycles, then bell_code=0 for GAP_TICKS cycles.
  - blink_en toggles at each note start when win=1; stays 0 otherwise.
  - After the last note's gap: DONE, bell_code=0, blink_en=0.
- DONE: holds match_cnt/win, done=1.
  - Leaves to IDLE (match_cnt, win, done cleared) on the first cycle flag!=0, i.e. a system restart.
- Abort: in any busy state, flag!=0 sends state to IDLE at the next edge.
  - bell_code=0 and blink_en=0 from that edge onward; match_cnt/win cleared.
- code changes after the trigger edge are ignored; the snapshot is authoritative.
- A trigger cannot occur outside IDLE. Trigger and abort conditions are mutually exclusive by construction.
- Tick counter is 28-bit, reset to 0 at every note/gap boundary, no wrap.
- Async rst mid-ANNOUNCE: bell_code=0 immediately, without waiting for clk.

Optional Feature:
- JUDGE_PARTIAL_MELODY_EN
- Defined: grades as above.
- Undefined:
  - Only 7 matches plays a jingle (1..7).
  - Any other count goes GRADE→DONE with bell_code held 0.
  - match_cnt/win are still reported.

Decomposition:
- Package selection_pkg holds:
  - state enum IDLE/CAPTURE/COMPARE/GRADE/ANNOUNCE/DONE
  - NUM_DIGITS=7, DIGIT_W=4
  - note constants NOTE_OFF=0 .. NOTE_TI=7
  - melody tables (21-bit packed note lists plus 3-bit lengths) for JACKPOT/BIG/SMALL
- One sub-module: note_sequencer.
  - Inputs: start, 21-bit melody, length.
  - Outputs: bell_code, note_start pulse, finished.
  - Owns the tick counter, note index and NOTE_TICKS/GAP_TICKS timing.
  - The judge FSM instantiates it once.

Test Plan (NOTE_TICKS=4, GAP_TICKS=2; feature defined unless stated):
1. target=28'h2F54321, flag 7F→00 with code=28'h2F54321 → match_cnt=7, win=1; bell_code sequence 1,2,...,7, each held 4 cycles with 2 zero cycles between; blink_en toggles 7 times; done=1 after 42 cycles of ANNOUNCE.
2. code=28'h2F54399 vs same target (5 matches) → match_cnt=5, win=1, melody 1,3,5, then DONE. With JUDGE_PARTIAL_MELODY_EN undefined → bell_code stays 0, done=1 right after GRADE.
3. code=28'h0A00000 vs target 28'h1B11111 (0 matches) → match_cnt=0, win=0, bell_code never nonzero, DONE 1 cycle after GRADE.
4. Flag returns to 7F during the third note of the jackpot → next edge bell_code=0, blink_en=0, match_cnt=0, busy=0, state IDLE; a fresh 7F→00 trigger is accepted afterwards.
5. Flag held 00 through reset release → no trigger and busy stays 0. Code toggled randomly during COMPARE → match_cnt still reflects the snapshot taken on the trigger edge.
6. Async rst asserted mid-COMPARE, off a clk edge → all outputs 0 immediately; after deassert, the next valid trigger grades correctly.
